// File: rtl/booth_mul_sched_pkg.sv
// Shared types and helpers for the booth_mul_sched multiplier engine.
// Holds the scheduler state encoding, the Booth digit selects and the step-count helper.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  typedef enum logic [2:0] {
    ZERO,
    PA,
    P2A,
    M2A,
    MA
  } booth_sel_e;

  // One radix-4 digit covers two multiplier bits, so odd widths need one extra step.
  function automatic int iter_of(input int width);
    return (width + 1) / 2;
  endfunction

endpackage

// File: rtl/booth_mul_sched_if.sv
// Client-facing bundle of booth_mul_sched: two operand requesters plus the tagged result.
// The master side is the client pair; the slave side is the multiplier engine.
interface booth_mul_sched_if #(
  parameter int WIDTH = 17
);

  logic [1:0]         req;
  logic [WIDTH-1:0]   a0;
  logic [WIDTH-1:0]   b0;
  logic [WIDTH-1:0]   a1;
  logic [WIDTH-1:0]   b1;
  logic [1:0]         gnt;
  logic               busy;
  logic               res_valid;
  logic               res_id;
  logic [2*WIDTH-1:0] result;

  modport master (
    output req, a0, b0, a1, b1,
    input  gnt, busy, res_valid, res_id, result
  );

  modport slave (
    input  req, a0, b0, a1, b1,
    output gnt, busy, res_valid, res_id, result
  );

endinterface

// File: rtl/booth_mul_sched_step.sv
// booth_r4_step: one combinational radix-4 Booth iteration on the {acc, y, y_-1} register.
// Decodes three multiplier bits, adds 0/+-A/+-2A to the accumulator, then shifts right by 2.
module booth_r4_step
  import booth_pkg::*;
#(
  parameter int WIDTH = 17,
  parameter int ITER  = 9
) (
  input  logic [WIDTH+1:0]  acc_i,
  input  logic [2*ITER-1:0] y_i,
  input  logic              ym1_i,
  input  logic [WIDTH-1:0]  a_i,
  output logic [WIDTH+1:0]  acc_o,
  output logic [2*ITER-1:0] y_o,
  output logic              ym1_o
);

  booth_sel_e               sel;
  logic signed [WIDTH+1:0]  a_ext;
  logic signed [WIDTH+1:0]  term;
  logic signed [WIDTH+1:0]  sum;

  always_comb begin
    sel = ZERO;
    case ({y_i[1:0], ym1_i})
      3'b001, 3'b010: sel = PA;
      3'b011:         sel = P2A;
      3'b100:         sel = M2A;
      3'b101, 3'b110: sel = MA;
      default:        sel = ZERO;
    endcase
  end

  // Two guard bits on the accumulator keep +-2A from ever overflowing.
  assign a_ext = (WIDTH+2)'($signed(a_i));

  always_comb begin
    term = '0;
    case (sel)
      PA:      term = a_ext;
      P2A:     term = a_ext <<< 1;
      M2A:     term = -(a_ext <<< 1);
      MA:      term = -a_ext;
      default: term = '0;
    endcase
  end

  assign sum   = $signed(acc_i) + term;
  assign acc_o = {{2{sum[WIDTH+1]}}, sum[WIDTH+1:2]};
  assign y_o   = {sum[1:0], y_i[2*ITER-1:2]};
  assign ym1_o = y_i[1];

endmodule

// File: rtl/booth_mul_sched.sv
// booth_mul_sched: two-client round-robin scheduler around one shared radix-4 Booth step unit.
// One Booth digit retires per clock; the exact product is returned tagged with its requester.
module booth_mul_sched
  import booth_pkg::*;
#(
  parameter int WIDTH = 17
) (
  input logic              clk,
  input logic              rst,
  booth_mul_sched_if.slave bus
);

  localparam int ITER  = iter_of(WIDTH);
  localparam int CNT_W = $clog2(ITER);

  state_e               state_q, state_d;
  logic [WIDTH+1:0]     acc_q, acc_d, step_acc;
  logic [2*ITER-1:0]    y_q, y_d, step_y;
  logic                 ym1_q, ym1_d, step_ym1;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 last_id_q, last_id_d;
  logic [1:0]           gnt_q, gnt_d;
  logic                 res_valid_q, res_valid_d;
  logic                 res_id_q, res_id_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 win;

  booth_r4_step #(
    .WIDTH (WIDTH),
    .ITER  (ITER)
  ) u_step (
    .acc_i (acc_q),
    .y_i   (y_q),
    .ym1_i (ym1_q),
    .a_i   (a_q),
    .acc_o (step_acc),
    .y_o   (step_y),
    .ym1_o (step_ym1)
  );

  // When both clients ask, the one not served last wins.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    y_d         = y_q;
    ym1_d       = ym1_q;
    a_d         = a_q;
    cnt_d       = cnt_q;
    last_id_d   = last_id_q;
    gnt_d       = 2'b00;
    res_valid_d = 1'b0;
    res_id_d    = res_id_q;
    result_d    = result_q;
    win         = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req != 2'b00) begin
          win       = (bus.req == 2'b11) ? ~last_id_q : bus.req[1];
          a_d       = win ? bus.a1 : bus.a0;
          y_d       = (2*ITER)'($signed(win ? bus.b1 : bus.b0));
          ym1_d     = 1'b0;
          acc_d     = '0;
          cnt_d     = '0;
          gnt_d     = win ? 2'b10 : 2'b01;
          last_id_d = win;
          state_d   = RUN;
        end
      end
      RUN: begin
        acc_d = step_acc;
        y_d   = step_y;
        ym1_d = step_ym1;
        if (cnt_q == CNT_W'(ITER - 1)) begin
          cnt_d       = '0;
          result_d    = (2*WIDTH)'({step_acc, step_y});
          res_id_d    = last_id_q;
          res_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      y_q         <= '0;
      ym1_q       <= 1'b0;
      a_q         <= '0;
      cnt_q       <= '0;
      last_id_q   <= 1'b1;
      gnt_q       <= 2'b00;
      res_valid_q <= 1'b0;
      res_id_q    <= 1'b0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      y_q         <= y_d;
      ym1_q       <= ym1_d;
      a_q         <= a_d;
      cnt_q       <= cnt_d;
      last_id_q   <= last_id_d;
      gnt_q       <= gnt_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      result_q    <= result_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.res_valid = res_valid_q;
  assign bus.res_id    = res_id_q;
  assign bus.result    = result_q;

endmodule

// File: tb/tb_booth_mul_sched.sv
// Directed self-checking bench for booth_mul_sched at the default 17-bit width.
// Expected products, grant order and latencies are hand-computed constants.
module tb_booth_mul_sched;

  localparam int W    = 17;
  localparam int ITER = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_gnt_cyc = 0;

  booth_mul_sched_if #(.WIDTH(W)) bus ();

  booth_mul_sched #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Waits for a grant, checks it, applies the post-grant stimulus, then checks the tagged result.
  task automatic apply_stimulus(input string tag, input logic [1:0] exp_gnt, input logic exp_id,
                                input logic [2*W-1:0] exp_res, input int exp_gap,
                                input logic [1:0] req_after, input logic upd,
                                input logic [W-1:0] na, input logic [W-1:0] nb,
                                input logic scramble);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.gnt == 2'b00 && n < 40);
    check_output({tag, ".gnt"}, 64'(bus.gnt), 64'(exp_gnt));
    if (exp_gap > 0) check_output({tag, ".gap"}, 64'(cyc - last_gnt_cyc), 64'(exp_gap));
    last_gnt_cyc = cyc;
    check_output({tag, ".busy"}, 64'(bus.busy), 64'(1'b1));
    bus.req = req_after;
    if (upd) begin
      if (exp_id) begin
        bus.a1 = na;
        bus.b1 = nb;
      end else begin
        bus.a0 = na;
        bus.b0 = nb;
      end
    end
    n = 0;
    do begin
      tick();
      n++;
      if (scramble && n == 1) begin
        bus.a0 = 17'h1ABCD;
        bus.b0 = 17'h0F0F3;
      end
    end while (!bus.res_valid && n < 40);
    check_output({tag, ".lat"}, 64'(n), 64'(ITER));
    check_output({tag, ".id"}, 64'(bus.res_id), 64'(exp_id));
    check_output({tag, ".result"}, 64'(bus.result), 64'(exp_res));
    tick();
    check_output({tag, ".busy_fall"}, 64'(bus.busy), 64'(1'b0));
    check_output({tag, ".rv_pulse"}, 64'(bus.res_valid), 64'(1'b0));
  endtask

  initial begin : main
    int pulses;
    $display("[TB] start");
    bus.req = 2'b11;
    bus.a0  = 17'h00003;
    bus.b0  = 17'h1FFFB;
    bus.a1  = 17'h1FFF9;
    bus.b1  = 17'h1FFF7;
    repeat (3) tick();
    check_output("rst.gnt", 64'(bus.gnt), 64'(2'b00));
    check_output("rst.busy", 64'(bus.busy), 64'(1'b0));
    check_output("rst.res_valid", 64'(bus.res_valid), 64'(1'b0));
    check_output("rst.res_id", 64'(bus.res_id), 64'(1'b0));
    check_output("rst.result", 64'(bus.result), 64'(0));
    rst = 1'b0;

    // Contention from reset: 3*-5 = -15 for client 0, -7*-9 = 63 for client 1.
    apply_stimulus("cont0", 2'b01, 1'b0, 34'h3_FFFF_FFF1, 0,  2'b11, 1'b0, '0, '0, 1'b0);
    apply_stimulus("cont1", 2'b10, 1'b1, 34'h0_0000_003F, 11, 2'b11, 1'b0, '0, '0, 1'b0);
    apply_stimulus("cont2", 2'b01, 1'b0, 34'h3_FFFF_FFF1, 11, 2'b00, 1'b0, '0, '0, 1'b0);

    // Single request, operands scrambled one cycle after the grant.
    bus.a0  = 17'h02727;
    bus.b0  = 17'h02727;
    bus.req = 2'b01;
    apply_stimulus("single", 2'b01, 1'b0, 34'h0_05FC_E7F1, 0, 2'b00, 1'b0, '0, '0, 1'b1);

    // Extreme operands on client 1.
    bus.a1 = 17'h10000; bus.b1 = 17'h10000; bus.req = 2'b10;
    apply_stimulus("ext_minsq", 2'b10, 1'b1, 34'h1_0000_0000, 0, 2'b00, 1'b0, '0, '0, 1'b0);
    bus.a1 = 17'h10000; bus.b1 = 17'h0FFFF; bus.req = 2'b10;
    apply_stimulus("ext_minmax", 2'b10, 1'b1, 34'h3_0001_0000, 0, 2'b00, 1'b0, '0, '0, 1'b0);
    bus.a1 = 17'h1FFFF; bus.b1 = 17'h1FFFF; bus.req = 2'b10;
    apply_stimulus("ext_m1sq", 2'b10, 1'b1, 34'h0_0000_0001, 0, 2'b00, 1'b0, '0, '0, 1'b0);
    bus.a1 = 17'h1FFFF; bus.b1 = 17'h00000; bus.req = 2'b10;
    apply_stimulus("ext_zero", 2'b10, 1'b1, 34'h0_0000_0000, 0, 2'b00, 1'b0, '0, '0, 1'b0);

    // Persistent client 0: 5*6, then -3*100, then 65535*65535.
    bus.a0 = 17'h00005; bus.b0 = 17'h00006; bus.req = 2'b01;
    apply_stimulus("pers0", 2'b01, 1'b0, 34'h0_0000_001E, 0,  2'b01, 1'b1, 17'h1FFFD, 17'h00064, 1'b0);
    apply_stimulus("pers1", 2'b01, 1'b0, 34'h3_FFFF_FED4, 11, 2'b01, 1'b1, 17'h0FFFF, 17'h0FFFF, 1'b0);
    apply_stimulus("pers2", 2'b01, 1'b0, 34'h0_FFFE_0001, 11, 2'b00, 1'b0, '0, '0, 1'b0);

    // Reset four cycles into a run aborts it and restores the round-robin pointer.
    bus.a0 = 17'h00007; bus.b0 = 17'h00007; bus.req = 2'b01;
    pulses = 0;
    do begin
      tick();
      pulses++;
    end while (bus.gnt == 2'b00 && pulses < 40);
    check_output("rst_mid.gnt", 64'(bus.gnt), 64'(2'b01));
    bus.req = 2'b00;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_output("rst_mid.busy", 64'(bus.busy), 64'(1'b0));
    check_output("rst_mid.gnt0", 64'(bus.gnt), 64'(2'b00));
    check_output("rst_mid.result", 64'(bus.result), 64'(0));
    check_output("rst_mid.res_id", 64'(bus.res_id), 64'(1'b0));
    pulses = 0;
    repeat (12) begin
      tick();
      if (bus.res_valid) pulses++;
    end
    check_output("rst_mid.no_valid", 64'(pulses), 64'(0));

    bus.a0 = 17'h00002; bus.b0 = 17'h00003;
    bus.a1 = 17'h00004; bus.b1 = 17'h00005;
    bus.req = 2'b11;
    apply_stimulus("post_rst", 2'b01, 1'b0, 34'h0_0000_0006, 0, 2'b00, 1'b0, '0, '0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/booth_mul_sched.md
# booth_mul_sched

Shared, iterative radix-4 Booth multiplier engine with a two-requester round-robin scheduler. The block replaces per-user pipelined multiplier arrays in area-constrained paths. It accepts signed operand pairs from two clients, grants one at a time, and runs one Booth radix-4 step per clock through a single reused step unit. It returns the full-precision product tagged with the requester ID.

## Interface
Parameters:
- WIDTH, 17, signed operand width in bits (two's complement); must be ≥ 4.
- ITER, (WIDTH+1)/2, Booth radix-4 step count (9 at default); derived, not overridden.

Ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  2  req[i] high: requester i has a valid operand pair; held until gnt[i].
- a0, b0  in  WIDTH  signed multiplicand / multiplier, requester 0.
- a1, b1  in  WIDTH  signed multiplicand / multiplier, requester 1.
- gnt  out  2  one-hot, one-cycle pulse; operands of that requester were captured at the preceding edge.
- busy  out  1  high whenever state ≠ IDLE.
- res_valid  out  1  one-cycle pulse; result and res_id are valid.
- res_id  out  1  requester that owns result.
- result  out  2*WIDTH  signed product a*b, exact (covers (−2^(W−1))² without overflow).

## Operation
- FSM states: IDLE, RUN, DONE.
- Reset values: state=IDLE, gnt=0, busy=0, res_valid=0, res_id=0, result=0, last_id=1, step counter=0.
- IDLE: if req≠0 at an edge, capture the winner's a/b, set gnt[winner] for the next cycle, record last_id=winner, clear the accumulator, load the multiplier with the appended bit y₋₁=0, go to RUN.
  - If req≠0 is not present, remain in IDLE.
- Arbitration: only one request raised, that one wins. Both raised, the winner is ~last_id (round-robin); after reset requester 0 wins first.
- RUN: each edge performs one step. Decode multiplier bits {y[2i+1], y[2i], y[2i−1]}:
  - 000/111 → 0; 001/010 → +A; 011 → +2A; 100 → −2A; 101/110 → −A.
  - Add the selected term to the upper accumulator, then arithmetic-shift {acc, y} right by 2.
  - The multiplier is sign-extended to 2*ITER bits. Accumulator width is WIDTH+2, so ±2A never overflows.
- After the ITER-th step: load result with the exact signed product sign-extended to 2*WIDTH bits, set res_id=last_id, go to DONE.
- DONE: res_valid=1 for this single cycle, then return to IDLE. No grant is issued in DONE.
- result and res_id hold their values until the next res_valid; they are not cleared on DONE exit.
- Operand changes after capture have no effect. req remaining high after gnt is treated as a new request.
- rst mid-RUN or in DONE aborts the operation: no res_valid, all registers return to reset values, and last_id returns to 1.
- rst has priority over every other event in the same cycle.

## Timing
- gnt is registered: high in cycle G, the cycle after the capturing edge.
- The step edges are the ITER edges following capture. res_valid is high in cycle G+ITER (G+9 at default).
- Minimum spacing between successive gnt pulses: ITER+2 cycles (11 at default). Throughput is one product per ITER+2 cycles.
- busy rises in cycle G and falls in the cycle after res_valid.
- No combinational path from inputs to outputs.

## Structure
- Package booth_pkg:
  - state enum {IDLE, RUN, DONE};
  - Booth digit select constants (ZERO, PA, P2A, M2A, MA);
  - function iter_of(width) = (width+1)/2.
- Sub-module booth_r4_step: purely combinational. It decodes three multiplier bits, selects 0/±A/±2A, adds, and arithmetic-shifts by 2.
- The scheduler FSM, round-robin register, operand capture and result register live in booth_mul_sched.

## Test plan
- Single request: req=01, a0=b0=0x02727 (10023). Expected: gnt=01 in cycle G; res_valid in G+9 with res_id=0 and result=0x0_05FC_E7F1; busy high G..G+9.
- Extremes on requester 1:
  - a1=b1=0x10000 (−65536) → result=0x1_0000_0000.
  - a1=0x10000, b1=0x0FFFF → result=0x3_0001_0000.
  - a1=b1=0x1FFFF (−1) → result=1.
  - a1=0x1FFFF, b1=0 → result=0.
- Contention: req=11 held from reset. Expected gnt sequence 01, 10, 01, with gnt pulses 11 cycles apart; res_id sequence 0, 1, 0, each result matching its operands.
- Persistent single requester: req=01 held for three products. Expected three back-to-back grants 11 cycles apart. Operands changed after each gnt are used only for the next product.
- Reset mid-RUN: assert rst for one cycle at G+4. Expected: no res_valid, busy=0 next cycle. With req=11 applied afterwards, gnt=01 is issued first.
- Operand stability: change a0/b0 in cycle G+1 after capture. The result reflects the captured values only.
